// File: rtl/fw_width_adapter.sv
// Narrow read port over a wide packet memory.
// One-entry wide-word cache plus per-word last/byte-count qualifiers.
module fw_width_adapter #(
  parameter int IN_WIDTH       = 64,
  parameter int OUT_WIDTH      = 32,
  parameter int IN_ADDR_WIDTH  = 9,
  parameter int OUT_ADDR_WIDTH = 10,
  parameter int MEM_LAT        = 1,
  parameter int PLEN_WIDTH     =
    OUT_ADDR_WIDTH + $clog2(OUT_WIDTH/8),
  parameter int BYTES_WIDTH    = $clog2(OUT_WIDTH/8) + 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [OUT_ADDR_WIDTH-1:0] fw_addr,
  input  logic                      fw_rd_en,
  output logic                      fw_rd_ready,
  output logic [OUT_WIDTH-1:0]      fw_rd_data,
  output logic                      fw_rd_valid,
  output logic                      fw_rd_last,
  output logic [BYTES_WIDTH-1:0]    fw_rd_bytes,
  input  logic                      fw_done,
  output logic [IN_ADDR_WIDTH-1:0]  mem_addr,
  output logic                      mem_rd_en,
  input  logic [IN_WIDTH-1:0]       mem_rd_data,
  input  logic [PLEN_WIDTH-1:0]     mem_byte_length,
  output logic                      mem_done
);

  localparam int RATIO = IN_WIDTH / OUT_WIDTH;
  localparam int N     = $clog2(RATIO);
  localparam int BW    = $clog2(OUT_WIDTH/8);
  localparam int NB    = OUT_WIDTH / 8;

  localparam logic signed [PLEN_WIDTH:0] NB_S =
    (PLEN_WIDTH+1)'(NB);
  localparam logic signed [PLEN_WIDTH:0] ZERO_S = '0;
  localparam logic [BYTES_WIDTH-1:0] NB_B =
    BYTES_WIDTH'(NB);

  typedef struct packed {
    logic                   vld;
    logic [N-1:0]           off;
    logic                   last;
    logic [BYTES_WIDTH-1:0] bytes;
  } ent_t;

  logic [IN_ADDR_WIDTH-1:0] tag;
  logic [N-1:0]             offset;
  logic [IN_WIDTH-1:0]      cache_data;
  logic [IN_ADDR_WIDTH-1:0] cache_tag;
  logic [IN_ADDR_WIDTH-1:0] miss_tag;
  logic                     cache_vld;
  logic                     pending;
  logic                     inval;
  logic                     accept;
  logic                     hit;
  logic                     miss;
  logic signed [PLEN_WIDTH:0] rem;
  logic                     q_last;
  logic [BYTES_WIDTH-1:0]   q_bytes;
  ent_t                     new_ent;
  ent_t                     tail;
  ent_t                     pipe [MEM_LAT];

  // Offset 0 is the MSB lane of the wide word.
  function automatic logic [OUT_WIDTH-1:0] lane(
    input logic [IN_WIDTH-1:0] w,
    input logic [N-1:0]        k
  );
    logic [IN_WIDTH-1:0] s;
    s = w << (OUT_WIDTH * int'(k));
    return s[IN_WIDTH-1 -: OUT_WIDTH];
  endfunction

  assign tag         = fw_addr[OUT_ADDR_WIDTH-1:N];
  assign offset      = fw_addr[N-1:0];
  assign mem_addr    = tag;
  assign mem_done    = fw_done;
  assign fw_rd_ready = !pending;
  assign accept      = fw_rd_en && !pending;
  assign hit  = accept && cache_vld && (tag == cache_tag);
  assign miss = accept && !hit;
  assign mem_rd_en   = miss;
  assign tail        = pipe[MEM_LAT-1];

  assign rem = $signed({1'b0, mem_byte_length})
             - $signed({1'b0, fw_addr, {BW{1'b0}}});

  always_comb begin
    q_last  = 1'b0;
    q_bytes = NB_B;
    if (rem > NB_S) begin
      q_last  = 1'b0;
      q_bytes = NB_B;
    end else if (rem > ZERO_S) begin
      q_last  = 1'b1;
      q_bytes = rem[BYTES_WIDTH-1:0];
    end else begin
      q_last  = 1'b1;
      q_bytes = '0;
    end
  end

  always_comb begin
    new_ent       = '0;
    new_ent.vld   = miss;
    new_ent.off   = offset;
    new_ent.last  = q_last;
    new_ent.bytes = q_bytes;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fw_rd_valid <= 1'b0;
      fw_rd_data  <= '0;
      fw_rd_last  <= 1'b0;
      fw_rd_bytes <= '0;
      cache_data  <= '0;
      cache_tag   <= '0;
      miss_tag    <= '0;
      cache_vld   <= 1'b0;
      pending     <= 1'b0;
      inval       <= 1'b0;
      for (int i = 0; i < MEM_LAT; i++) pipe[i] <= '0;
    end else begin
      fw_rd_valid <= 1'b0;
      pipe[0]     <= new_ent;
      for (int i = 1; i < MEM_LAT; i++) pipe[i] <= pipe[i-1];
      if (tail.vld) begin
        cache_data  <= mem_rd_data;
        cache_tag   <= miss_tag;
        cache_vld   <= !inval;
        pending     <= 1'b0;
        fw_rd_valid <= 1'b1;
        fw_rd_data  <= lane(mem_rd_data, tail.off);
        fw_rd_last  <= tail.last;
        fw_rd_bytes <= tail.bytes;
      end else if (hit) begin
        fw_rd_valid <= 1'b1;
        fw_rd_data  <= lane(cache_data, offset);
        fw_rd_last  <= q_last;
        fw_rd_bytes <= q_bytes;
      end
      // done during a fetch keeps the arriving word uncached
      if (miss) begin
        pending  <= 1'b1;
        miss_tag <= tag;
        inval    <= fw_done;
      end else if (fw_done) begin
        inval <= 1'b1;
      end
      if (fw_done) cache_vld <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fw_width_adapter.sv
// Directed bench for fw_width_adapter.
// Three instances cover memory latencies 1, 2 and 3.
module tb_fw_width_adapter;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  addr;
  logic        done;
  logic [11:0] len;

  logic        en1, rdy1, val1, last1, mre1, mdone1;
  logic [31:0] data1;
  logic [2:0]  bytes1;
  logic [8:0]  maddr1;
  logic [63:0] md1;

  logic        en2, rdy2, val2, last2, mre2, mdone2;
  logic [31:0] data2;
  logic [2:0]  bytes2;
  logic [8:0]  maddr2;
  logic [63:0] md2, md2a;

  logic        en3, rdy3, val3, last3, mre3, mdone3;
  logic [31:0] data3;
  logic [2:0]  bytes3;
  logic [8:0]  maddr3;
  logic [63:0] md3, md3a, md3b;

  logic [63:0] mem [4];
  logic [8:0]  mlog1 [8];
  int cnt1 = 0, cnt2 = 0, cnt3 = 0, vcnt2 = 0;
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  fw_width_adapter #(.MEM_LAT(1)) u1 (
    .clk(clk), .rst(rst), .fw_addr(addr),
    .fw_rd_en(en1), .fw_rd_ready(rdy1),
    .fw_rd_data(data1), .fw_rd_valid(val1),
    .fw_rd_last(last1), .fw_rd_bytes(bytes1),
    .fw_done(done), .mem_addr(maddr1),
    .mem_rd_en(mre1), .mem_rd_data(md1),
    .mem_byte_length(len), .mem_done(mdone1)
  );

  fw_width_adapter #(.MEM_LAT(2)) u2 (
    .clk(clk), .rst(rst), .fw_addr(addr),
    .fw_rd_en(en2), .fw_rd_ready(rdy2),
    .fw_rd_data(data2), .fw_rd_valid(val2),
    .fw_rd_last(last2), .fw_rd_bytes(bytes2),
    .fw_done(done), .mem_addr(maddr2),
    .mem_rd_en(mre2), .mem_rd_data(md2),
    .mem_byte_length(len), .mem_done(mdone2)
  );

  fw_width_adapter #(.MEM_LAT(3)) u3 (
    .clk(clk), .rst(rst), .fw_addr(addr),
    .fw_rd_en(en3), .fw_rd_ready(rdy3),
    .fw_rd_data(data3), .fw_rd_valid(val3),
    .fw_rd_last(last3), .fw_rd_bytes(bytes3),
    .fw_done(done), .mem_addr(maddr3),
    .mem_rd_en(mre3), .mem_rd_data(md3),
    .mem_byte_length(len), .mem_done(mdone3)
  );

  // memories with fixed read latency
  always @(posedge clk) begin
    md1  <= mem[maddr1[1:0]];
    md2a <= mem[maddr2[1:0]];
    md2  <= md2a;
    md3a <= mem[maddr3[1:0]];
    md3b <= md3a;
    md3  <= md3b;
    if (mre1) begin
      mlog1[cnt1 % 8] <= maddr1;
      cnt1 <= cnt1 + 1;
    end
    if (mre2) cnt2 <= cnt2 + 1;
    if (mre3) cnt3 <= cnt3 + 1;
    if (val2) vcnt2 <= vcnt2 + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string t,
                     input logic [63:0] o,
                     input logic [63:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", t, o, e);
    end
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic req1(input  logic [9:0]  a,
                      output logic [31:0] d,
                      output logic        l,
                      output logic [2:0]  b);
    int n;
    addr = a;
    en1  = 1'b1;
    n = 0;
    while (!rdy1 && n < 20) begin tick(); n++; end
    tick();
    en1 = 1'b0;
    n = 0;
    while (!val1 && n < 20) begin tick(); n++; end
    chk("req1_valid", 64'(val1), 64'd1);
    d = data1;
    l = last1;
    b = bytes1;
  endtask

  initial begin
    logic [31:0] d;
    logic        l;
    logic [2:0]  b;
    logic [31:0] exp_d [4];
    int s, v;

    mem[0] = 64'h11111111_22222222;
    mem[1] = 64'hAAAAAAAA_BBBBBBBB;
    mem[2] = 64'h33333333_44444444;
    mem[3] = 64'h55555555_66666666;
    exp_d[0] = 32'h11111111;
    exp_d[1] = 32'h22222222;
    exp_d[2] = 32'hAAAAAAAA;
    exp_d[3] = 32'hBBBBBBBB;
    rst = 1'b1; addr = '0; done = 1'b0; len = 12'd64;
    en1 = 1'b0; en2 = 1'b0; en3 = 1'b0;
    repeat (3) tick();

    chk("rst_valid", 64'(val1), 64'd0);
    chk("rst_data",  64'(data1), 64'd0);
    chk("rst_last",  64'(last1), 64'd0);
    chk("rst_bytes", 64'(bytes1), 64'd0);
    chk("rst_ready1", 64'(rdy1), 64'd1);
    chk("rst_ready3", 64'(rdy3), 64'd1);
    rst = 1'b0;
    tick();

    // miss then hit, latency 1
    s = cnt1;
    addr = 10'd0; en1 = 1'b1;
    @(negedge clk);
    chk("miss_mre", 64'(mre1), 64'd1);
    chk("miss_maddr", 64'(maddr1), 64'd0);
    tick();
    en1 = 1'b0;
    @(negedge clk);
    chk("miss_ready_low", 64'(rdy1), 64'd0);
    chk("miss_not_yet", 64'(val1), 64'd0);
    tick();
    chk("miss_valid", 64'(val1), 64'd1);
    chk("miss_data", 64'(data1), 64'h11111111);
    chk("miss_ready_back", 64'(rdy1), 64'd1);
    addr = 10'd1; en1 = 1'b1;
    @(negedge clk);
    chk("hit_no_mre", 64'(mre1), 64'd0);
    tick();
    en1 = 1'b0;
    chk("hit_valid", 64'(val1), 64'd1);
    chk("hit_data", 64'(data1), 64'h22222222);
    chk("hit_last", 64'(last1), 64'd0);
    chk("hit_bytes", 64'(bytes1), 64'd4);
    tick();
    chk("valid_pulse", 64'(val1), 64'd0);
    chk("data_hold", 64'(data1), 64'h22222222);
    chk("mh_mre_cnt", 64'(cnt1 - s), 64'd1);

    // tag change over two wide words
    pulse_rst();
    s = cnt1;
    for (int i = 0; i < 4; i++) begin
      req1(10'(i), d, l, b);
      chk("tag_data", 64'(d), 64'(exp_d[i]));
    end
    chk("tag_mre_cnt", 64'(cnt1 - s), 64'd2);
    chk("tag_maddr0", 64'(mlog1[s % 8]), 64'd0);
    chk("tag_maddr1", 64'(mlog1[(s+1) % 8]), 64'd1);

    // length qualifiers
    len = 12'd6;
    req1(10'd0, d, l, b);
    chk("len0_last", 64'(l), 64'd0);
    chk("len0_bytes", 64'(b), 64'd4);
    req1(10'd1, d, l, b);
    chk("len1_last", 64'(l), 64'd1);
    chk("len1_bytes", 64'(b), 64'd2);
    req1(10'd2, d, l, b);
    chk("len2_last", 64'(l), 64'd1);
    chk("len2_bytes", 64'(b), 64'd0);
    len = 12'd64;

    // back-pressure with latency 3
    pulse_rst();
    tick();
    s = cnt3;
    addr = 10'd0; en3 = 1'b1;
    @(negedge clk);
    chk("bp_mre", 64'(mre3), 64'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      @(negedge clk);
      chk("bp_ready_low", 64'(rdy3), 64'd0);
      chk("bp_no_mre", 64'(mre3), 64'd0);
    end
    tick();
    chk("bp_ready_high", 64'(rdy3), 64'd1);
    chk("bp_miss_valid", 64'(val3), 64'd1);
    chk("bp_miss_data", 64'(data3), 64'h11111111);
    @(negedge clk);
    chk("bp_held_hit", 64'(mre3), 64'd0);
    tick();
    en3 = 1'b0;
    chk("bp_hit_valid", 64'(val3), 64'd1);
    chk("bp_hit_data", 64'(data3), 64'h11111111);
    chk("bp_mre_cnt", 64'(cnt3 - s), 64'd1);

    // done invalidates the cache
    pulse_rst();
    s = cnt1;
    req1(10'd0, d, l, b);
    req1(10'd0, d, l, b);
    chk("done_hit_data", 64'(d), 64'h11111111);
    chk("done_pre_cnt", 64'(cnt1 - s), 64'd1);
    done = 1'b1;
    @(negedge clk);
    chk("mem_done_hi", 64'(mdone1), 64'd1);
    tick();
    done = 1'b0;
    @(negedge clk);
    chk("mem_done_lo", 64'(mdone1), 64'd0);
    tick();
    req1(10'd1, d, l, b);
    chk("done_refetch", 64'(cnt1 - s), 64'd2);
    chk("done_data", 64'(d), 64'h22222222);

    // reset in the middle of a miss, latency 2
    pulse_rst();
    addr = 10'd2; en2 = 1'b1;
    tick();
    en2 = 1'b0;
    repeat (2) tick();
    chk("l2_valid", 64'(val2), 64'd1);
    chk("l2_data", 64'(data2), 64'hAAAAAAAA);
    chk("l2_bytes", 64'(bytes2), 64'd4);
    tick();
    addr = 10'd0; en2 = 1'b1;
    @(negedge clk);
    chk("l2_miss_mre", 64'(mre2), 64'd1);
    tick();
    en2 = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("mr_valid", 64'(val2), 64'd0);
    chk("mr_data", 64'(data2), 64'd0);
    chk("mr_last", 64'(last2), 64'd0);
    chk("mr_bytes", 64'(bytes2), 64'd0);
    chk("mr_ready", 64'(rdy2), 64'd1);
    tick();
    rst = 1'b0;
    v = vcnt2;
    repeat (4) tick();
    chk("mr_no_stale", 64'(vcnt2 - v), 64'd0);
    s = cnt2;
    addr = 10'd0; en2 = 1'b1;
    @(negedge clk);
    chk("mr_reissue", 64'(mre2), 64'd1);
    tick();
    en2 = 1'b0;
    chk("mr_reissue_cnt", 64'(cnt2 - s), 64'd1);
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
